// File: rtl/cache_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_types_pkg
// Description : Shared FSM state encoding, arbitration-mode constants and
//               port-count limits for the L1-to-L2 request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_types_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    localparam int N_PORTS_MIN = 2;
    localparam int N_PORTS_MAX = 8;

    // Index width for a port count; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner selection, round-robin from a pointer
//               or fixed priority with index 0 highest.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import cache_types_pkg::*;
#(
    parameter  int N_PORTS = 2,
    localparam int IDX_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               mode_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);

    int w_base;
    int w_dist;
    int w_best;

    // The requester with the smallest upward distance from the base wins;
    // a zero base degenerates to lowest-index priority.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        w_base  = mode_i ? int'(ptr_i) : 0;
        w_dist  = 0;
        w_best  = N_PORTS;
        for (int i = 0; i < N_PORTS; i++) begin
            w_dist = (i + N_PORTS - w_base) % N_PORTS;
            if (req_i[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                grant_o = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_rr_arbiter
// Description : N-port line-request arbiter between L1 caches and the L2,
//               one outstanding downstream transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_rr_arbiter
    import cache_types_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int S_LINE  = 256,
    parameter int RR_MODE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_PORTS-1:0]            up_read,
    input  logic [N_PORTS-1:0]            up_write,
    input  logic [N_PORTS-1:0][31:0]      up_address,
    input  logic [N_PORTS-1:0][S_LINE-1:0] up_wdata,
    output logic [S_LINE-1:0]             up_rdata,
    output logic [N_PORTS-1:0]            up_resp,
    output logic                          dn_read,
    output logic                          dn_write,
    output logic [31:0]                   dn_address,
    output logic [S_LINE-1:0]             dn_wdata,
    input  logic [S_LINE-1:0]             dn_rdata,
    input  logic                          dn_resp
);

    localparam int IDX_W = idx_width(N_PORTS);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [IDX_W-1:0]   gnt_q,   gnt_d;
    logic [31:0]        addr_q,  addr_d;
    logic [S_LINE-1:0]  wdata_q, wdata_d;
    logic               wr_q,    wr_d;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_gnt_next;
    logic               w_mode_rr;

    assign w_mode_rr  = (RR_MODE == ARB_MODE_RR);
    assign w_gnt_next = (gnt_q == IDX_W'(N_PORTS - 1)) ? '0 : gnt_q + 1'b1;

    rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .req_i   (up_read | up_write),
        .ptr_i   (ptr_q),
        .mode_i  (w_mode_rr),
        .grant_o (w_pick_idx),
        .valid_o (w_pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        up_resp = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    gnt_d   = w_pick_idx;
                    addr_d  = up_address[w_pick_idx];
                    wdata_d = up_wdata[w_pick_idx];
                    // A simultaneous read+write is served as a write.
                    wr_d    = up_write[w_pick_idx];
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dn_resp) begin
                    up_resp[gnt_q] = 1'b1;
                    if (w_mode_rr) begin
                        ptr_d = w_gnt_next;
                    end
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs derive from async-cleared state, so reset silences them at once.
    assign dn_read    = (state_q == ST_BUSY) && !wr_q;
    assign dn_write   = (state_q == ST_BUSY) &&  wr_q;
    assign dn_address = addr_q;
    assign dn_wdata   = wdata_q;
    assign up_rdata   = dn_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_rr_arbiter
// Description : Directed self-checking bench for cache_rr_arbiter with a
//               4-port round-robin instance and a 4-port fixed-priority one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_rr_arbiter;

    localparam int NP = 4;
    localparam int SL = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Round-robin instance
    logic [NP-1:0]          rd, wr;
    logic [NP-1:0][31:0]    addr;
    logic [NP-1:0][SL-1:0]  wdata;
    logic [SL-1:0]          rdata;
    logic [NP-1:0]          resp;
    logic                   dn_rd, dn_wr;
    logic [31:0]            dn_addr;
    logic [SL-1:0]          dn_wd;
    logic [SL-1:0]          dn_rdata;
    logic                   dn_resp;

    // Fixed-priority instance
    logic [NP-1:0]          f_rd, f_wr;
    logic [NP-1:0][31:0]    f_addr;
    logic [NP-1:0][SL-1:0]  f_wdata;
    logic [SL-1:0]          f_rdata;
    logic [NP-1:0]          f_resp;
    logic                   f_dn_rd, f_dn_wr;
    logic [31:0]            f_dn_addr;
    logic [SL-1:0]          f_dn_wd;
    logic [SL-1:0]          f_dn_rdata;
    logic                   f_dn_resp;

    int n_assert = 0;
    int n_fail   = 0;

    logic [SL-1:0] line_aa;
    logic [SL-1:0] line_55;

    cache_rr_arbiter #(.N_PORTS(NP), .S_LINE(SL), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .up_read(rd), .up_write(wr), .up_address(addr), .up_wdata(wdata),
        .up_rdata(rdata), .up_resp(resp),
        .dn_read(dn_rd), .dn_write(dn_wr), .dn_address(dn_addr), .dn_wdata(dn_wd),
        .dn_rdata(dn_rdata), .dn_resp(dn_resp)
    );

    cache_rr_arbiter #(.N_PORTS(NP), .S_LINE(SL), .RR_MODE(0)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .up_read(f_rd), .up_write(f_wr), .up_address(f_addr), .up_wdata(f_wdata),
        .up_rdata(f_rdata), .up_resp(f_resp),
        .dn_read(f_dn_rd), .dn_write(f_dn_wr), .dn_address(f_dn_addr), .dn_wdata(f_dn_wd),
        .dn_rdata(f_dn_rdata), .dn_resp(f_dn_resp)
    );

    task automatic chk(input string tag, input logic [SL-1:0] obs, input logic [SL-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line_aa = {32{8'hAA}};
        line_55 = {32{8'h55}};
        rst_n = 1'b0;
        rd = '0; wr = '0; addr = '0; wdata = '0; dn_rdata = '0; dn_resp = 1'b0;
        f_rd = '0; f_wr = '0; f_addr = '0; f_wdata = '0; f_dn_rdata = '0; f_dn_resp = 1'b0;
        settle();
        chk("reset dn_read",    SL'(dn_rd),   '0);
        chk("reset dn_write",   SL'(dn_wr),   '0);
        chk("reset up_resp",    SL'(resp),    '0);
        chk("reset dn_address", SL'(dn_addr), '0);
        chk("reset dn_wdata",   dn_wd,        '0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Port 0 read, response on the third BUSY cycle
        cyc();
        rd[0] = 1'b1; addr[0] = 32'h0000_1000;
        settle();
        chk("s1 idle dn_read", SL'(dn_rd), '0);
        cyc(); settle();
        chk("s1 busy1 dn_read", SL'(dn_rd), 1);
        chk("s1 busy1 addr", SL'(dn_addr), SL'(32'h0000_1000));
        chk("s1 busy1 resp", SL'(resp), '0);
        cyc(); settle();
        chk("s1 busy2 dn_read", SL'(dn_rd), 1);
        cyc();
        dn_resp = 1'b1; dn_rdata = line_aa;
        settle();
        chk("s1 busy3 dn_read", SL'(dn_rd), 1);
        chk("s1 busy3 resp", SL'(resp), SL'(4'b0001));
        chk("s1 busy3 rdata", rdata, line_aa);
        cyc();
        dn_resp = 1'b0;
        settle();
        chk("s1 recover dn_read", SL'(dn_rd), '0);
        chk("s1 recover resp", SL'(resp), '0);
        cyc();
        rd[0] = 1'b0;
        settle();
        chk("s1 idle-after-recover dn_read", SL'(dn_rd), '0);
        cyc(); settle();
        chk("s1 stays idle", SL'(dn_rd), '0);

        // Reset so the rotation starts at port 0; all ports request continuously
        rst_n = 1'b0; settle(); rst_n = 1'b1;
        cyc();
        for (int i = 0; i < NP; i++) addr[i] = 32'h100 * (i + 1);
        rd = 4'b1111; dn_resp = 1'b1; dn_rdata = line_55;
        settle();
        chk("s2 idle resp", SL'(resp), '0);
        chk("s2 idle dn_read", SL'(dn_rd), '0);
        for (int t = 0; t < 5; t++) begin
            cyc(); settle();
            chk("s2 busy addr", SL'(dn_addr), SL'(32'h100 * ((t % 4) + 1)));
            chk("s2 busy resp", SL'(resp), SL'(4'b0001 << (t % 4)));
            chk("s2 busy dn_read", SL'(dn_rd), 1);
            cyc(); settle();
            chk("s2 recover dn_read", SL'(dn_rd), '0);
            chk("s2 recover resp", SL'(resp), '0);
            cyc(); settle();
            chk("s2 idle dn_read", SL'(dn_rd), '0);
            chk("s2 idle resp", SL'(resp), '0);
        end
        rd = '0; dn_resp = 1'b0;

        // Port 2 write; its address and data change while BUSY (ptr is now 1)
        cyc();
        wr[2] = 1'b1; addr[2] = 32'h8000_0040; wdata[2] = line_55;
        cyc(); settle();
        chk("s3 dn_write", SL'(dn_wr), 1);
        chk("s3 dn_read", SL'(dn_rd), '0);
        chk("s3 addr", SL'(dn_addr), SL'(32'h8000_0040));
        chk("s3 wdata", dn_wd, line_55);
        addr[2] = 32'hDEAD_0000; wdata[2] = '0;
        cyc(); settle();
        chk("s3 held addr", SL'(dn_addr), SL'(32'h8000_0040));
        chk("s3 held wdata", dn_wd, line_55);
        chk("s3 held dn_write", SL'(dn_wr), 1);
        dn_resp = 1'b1; settle();
        chk("s3 resp", SL'(resp), SL'(4'b0100));
        cyc();
        dn_resp = 1'b0; wr[2] = 1'b0;
        settle();
        chk("s3 recover dn_write", SL'(dn_wr), '0);
        cyc();

        // Port 1 read and write together (ptr is now 3)
        rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h0000_2000;
        cyc(); settle();
        chk("s4 dn_write", SL'(dn_wr), 1);
        chk("s4 dn_read", SL'(dn_rd), '0);
        chk("s4 addr", SL'(dn_addr), SL'(32'h0000_2000));
        dn_resp = 1'b1; settle();
        chk("s4 resp", SL'(resp), SL'(4'b0010));
        cyc();
        dn_resp = 1'b0; rd[1] = 1'b0; wr[1] = 1'b0;
        cyc();

        // ptr is now 2: ports 0 and 3 request, port 3 wins then port 0
        rd[0] = 1'b1; rd[3] = 1'b1; addr[0] = 32'h0000_0A00; addr[3] = 32'h0000_0D00;
        cyc(); settle();
        chk("s5 first addr", SL'(dn_addr), SL'(32'h0000_0D00));
        dn_resp = 1'b1; settle();
        chk("s5 first resp", SL'(resp), SL'(4'b1000));
        cyc();
        dn_resp = 1'b0; rd[3] = 1'b0;
        cyc(); cyc(); settle();
        chk("s5 second addr", SL'(dn_addr), SL'(32'h0000_0A00));
        chk("s5 second dn_read", SL'(dn_rd), 1);
        dn_resp = 1'b1; settle();
        chk("s5 second resp", SL'(resp), SL'(4'b0001));
        cyc();
        dn_resp = 1'b0; rd[0] = 1'b0;
        cyc();

        // Reset asserted between edges during BUSY
        rd[1] = 1'b1; addr[1] = 32'h0000_3000;
        cyc(); settle();
        chk("s6 busy dn_read", SL'(dn_rd), 1);
        #2;
        rst_n = 1'b0;
        settle();
        chk("s6 reset dn_read", SL'(dn_rd), '0);
        chk("s6 reset addr", SL'(dn_addr), '0);
        chk("s6 reset resp", SL'(resp), '0);
        rd[1] = 1'b0;
        cyc();
        rst_n = 1'b1; dn_resp = 1'b1;
        settle();
        chk("s6 late dn_resp resp", SL'(resp), '0);
        cyc(); settle();
        chk("s6 late dn_resp resp2", SL'(resp), '0);
        chk("s6 late dn_resp dn_read", SL'(dn_rd), '0);
        dn_resp = 1'b0;

        // Fixed priority: ports 1 and 3, port 1 served until it drops
        cyc();
        f_rd[1] = 1'b1; f_rd[3] = 1'b1;
        f_addr[1] = 32'h0000_1100; f_addr[3] = 32'h0000_3300;
        cyc(); settle();
        chk("fx first addr", SL'(f_dn_addr), SL'(32'h0000_1100));
        f_dn_resp = 1'b1; settle();
        chk("fx first resp", SL'(f_resp), SL'(4'b0010));
        cyc();
        f_dn_resp = 1'b0;
        cyc(); cyc(); settle();
        chk("fx second addr", SL'(f_dn_addr), SL'(32'h0000_1100));
        f_dn_resp = 1'b1; settle();
        chk("fx second resp", SL'(f_resp), SL'(4'b0010));
        cyc();
        f_dn_resp = 1'b0; f_rd[1] = 1'b0;
        cyc(); cyc(); settle();
        chk("fx third addr", SL'(f_dn_addr), SL'(32'h0000_3300));
        f_dn_resp = 1'b1; settle();
        chk("fx third resp", SL'(f_resp), SL'(4'b1000));
        cyc();
        f_dn_resp = 1'b0; f_rd[3] = 1'b0;
        cyc(); settle();
        chk("fx idle dn_read", SL'(f_dn_rd), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_rr_arbiter.md
CACHE_RR_ARBITER -- requirements
Module: cache_rr_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of upstream cache ports; legal range 2..8.
REQ-002 SHALL have parameter S_LINE, default 256: line width in bits.
REQ-003 SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port up_read, input, N_PORTS bits: per-port line-read request.
REQ-007 SHALL have port up_write, input, N_PORTS bits: per-port line-write request.
REQ-008 SHALL have port up_address, input, N_PORTS x 32 bits: per-port line address.
REQ-009 SHALL have port up_wdata, input, N_PORTS x S_LINE bits: per-port write line.
REQ-010 SHALL have port up_rdata, output, S_LINE bits: returned line, shared by all ports.
REQ-011 SHALL have port up_resp, output, N_PORTS bits: per-port completion, one-hot or zero.
REQ-012 SHALL have ports dn_read and dn_write, output, 1 bit each: downstream request.
REQ-013 SHALL have port dn_address, output, 32 bits: downstream address.
REQ-014 SHALL have port dn_wdata, output, S_LINE bits: downstream write line.
REQ-015 SHALL have port dn_rdata, input, S_LINE bits: downstream read line.
REQ-016 SHALL have port dn_resp, input, 1 bit: downstream completion.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and RECOVER.
REQ-018 IDLE: a port is requesting when up_read[i] or up_write[i] is high; if any port requests, SHALL pick a winner g, register g, its address, its wdata and its op, then go to BUSY next cycle.
REQ-019 Winner selection SHALL, with RR_MODE=1, be the first requesting index at or after pointer ptr, searching upward and wrapping at N_PORTS-1 back to 0.
REQ-020 Winner selection SHALL, with RR_MODE=0, be the lowest requesting index.
REQ-021 If a port asserts both read and write, SHALL treat the request as a write.
REQ-022 BUSY: dn_read or dn_write SHALL be driven from the registered op; dn_address and dn_wdata SHALL come from registered copies, stable until dn_resp.
REQ-023 BUSY with dn_resp=1: up_resp[g] SHALL pulse in that same cycle (0 added latency) and up_rdata SHALL equal dn_rdata combinationally.
REQ-024 In the same dn_resp cycle: dn_read and dn_write SHALL drop in the next cycle, ptr SHALL load (g+1) mod N_PORTS (RR_MODE=1 only), and the FSM SHALL go to RECOVER.
REQ-025 RECOVER SHALL last exactly 1 cycle, issue no grant, and go to IDLE; this prevents re-granting a request the served cache has not yet dropped.
REQ-026 Requests arriving while in BUSY or RECOVER SHALL be held off, with no up_resp, and arbitrated in IDLE.
REQ-027 Outside a dn_resp cycle, up_resp SHALL be 0 and up_rdata SHALL be dn_rdata, which is don't-care.
REQ-028 In any state other than BUSY, dn_read and dn_write SHALL be 0.
REQ-029 Worst-case wait for a held request SHALL be bounded by (N_PORTS-1) transactions in RR_MODE=1.

Reset
REQ-030 While rst_n=0, the FSM SHALL be IDLE, ptr and g SHALL be 0, and registered address, wdata and op SHALL be 0.
REQ-031 Reset SHALL make dn_read, dn_write, up_resp, dn_address and dn_wdata 0 immediately, without waiting for clk.
REQ-032 Reset asserted mid-BUSY SHALL abandon the transaction with no up_resp; a dn_resp arriving after reset SHALL be ignored while in IDLE.

Structure
REQ-033 The FSM state enum, the arbitration-mode constants and the N_PORTS range limit SHALL live in shared package cache_types_pkg.
REQ-034 Winner selection SHALL be a sub-module rr_pick: inputs are the request vector, ptr and mode; output is the winner index plus a valid bit; it SHALL be purely combinational.
REQ-035 The block SHALL be drop-in between the L1 cache cores and the L2 cache core, replacing the 2-port arbitration with N_PORTS configurable.

Verification
REQ-036 Scenario: N=2, RR; port0 read at 0x0000_1000, dn_resp 3 cycles after BUSY entry with dn_rdata=0xAA..AA -> dn_read held 3 cycles, up_resp=01 in the dn_resp cycle, up_rdata=0xAA..AA, then 1 RECOVER cycle.
REQ-037 Scenario: N=4, RR, all ports requesting continuously, dn_resp=1 every BUSY cycle -> grant order 0,1,2,3,0,…, and each transaction occupies exactly 3 cycles (IDLE, BUSY, RECOVER).
REQ-038 Scenario: N=4, RR_MODE=0, ports 1 and 3 requesting -> port 1 served first; port 3 served only after port 1 drops.
REQ-039 Scenario: port2 write to 0x8000_0040 with wdata=0x55..55, while up_address[2] changes during BUSY -> dn_address stays 0x8000_0040 and dn_write=1 until dn_resp.
REQ-040 Scenario: rst_n driven low mid-BUSY between clock edges -> dn_read drops immediately, up_resp stays 0, and a later dn_resp pulse causes no up_resp.
REQ-041 Scenario: port1 asserts read and write together -> dn_write=1 and dn_read=0.
